// File: rtl/mux16_arbiter.sv
// mux16_arbiter: two-source valid/ready arbiter sharing one 16-bit output
// register through a Mux16 instance.
// Build option: define MUX16_ARB_RR_EN for round-robin priority. When it is
// left undefined, source A has fixed priority over source B.

// Mux16: 2:1 word selector; sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux16 (
  input  logic        sel_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module mux16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_valid_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_ready_o,
  input  logic             b_valid_i,
  input  logic [WIDTH-1:0] b_data_i,
  output logic             b_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i,
  output logic             src_o
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state, state_n;
  logic             pri;
  logic             slot_free;
  logic             win_b;
  logic             accept;
  logic [WIDTH-1:0] mux_y;

  // Winner and handshake decode; readys see only control signals, never data.
  assign slot_free = (state == EMPTY) || out_ready_i;
  assign win_b     = b_valid_i && (!a_valid_i || pri);
  assign a_ready_o = !rst_i && slot_free && a_valid_i && !win_b;
  assign b_ready_o = !rst_i && slot_free && win_b;
  assign accept    = a_ready_o || b_ready_o;

  assign out_valid_o = (state == FULL);

  mux16 u_mux16 (
    .sel_i (win_b),
    .a_i   (a_data_i),
    .b_i   (b_data_i),
    .y_o   (mux_y)
  );

  // Occupancy state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_n;
  end

  // Next occupancy: an accept fills the slot, a bare drain empties it.
  always_comb begin
    state_n = state;
    if (accept)           state_n = FULL;
    else if (out_ready_i) state_n = EMPTY;
  end

  // Output word and its source index load only on accept; a drain holds them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_data_o <= '0;
      src_o      <= 1'b0;
    end else if (accept) begin
      out_data_o <= mux_y;
      src_o      <= win_b;
    end
  end

`ifdef MUX16_ARB_RR_EN
  // Round-robin: after each accept the loser gets priority on the next tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       pri <= 1'b0;
    else if (accept) pri <= !win_b;
  end
`else
  assign pri = 1'b0;
`endif

endmodule

// File: doc/mux16_arbiter.md
# mux16_arbiter

Two-requester arbiter that shares one 16-bit output channel, built around a Mux16 instance, between sources A and B. Each source presents data under a valid/ready handshake. The arbiter picks a winner, steers the winner's word through the Mux16 into a one-entry output register, and presents it downstream under a second valid/ready handshake. It sits between two producers in the datapath and a single consumer of 16-bit words.

## Interface
- `WIDTH`, 16: data width; the Mux16 datapath fixes it at 16.
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `a_valid_i`  in  1  source A has a word.
- `a_data_i`  in  16  source A word.
- `a_ready_o`  out  1  source A word accepted this cycle.
- `b_valid_i`  in  1  source B has a word.
- `b_data_i`  in  16  source B word.
- `b_ready_o`  out  1  source B word accepted this cycle.
- `out_valid_o`  out  1  output register holds a word.
- `out_data_o`  out  16  output word.
- `out_ready_i`  in  1  consumer takes the word this cycle.
- `src_o`  out  1  source of the current output word: 0 = A, 1 = B.

## Operation
- The arbiter has two states, encoded by `out_valid_o`:
  - EMPTY (0): the output register is free.
  - FULL (1): the output register holds a word.
- `slot_free = !out_valid_o || out_ready_i`.
- Winner selection is combinational, from `a_valid_i`, `b_valid_i` and the priority bit `pri`:
  - Only one source valid: that source wins.
  - Both valid: `pri` wins (0 = A, 1 = B).
  - Neither valid: no winner.
- The Mux16 select is the winner index: A feeds `a_i`, B feeds `b_i`.
- Ready: `a_ready_o = slot_free && winner==A && a_valid_i`. `b_ready_o` is defined the same way for B. At most one ready is high in any cycle.
- Accept (a winner's ready is high):
  - The register loads the Mux16 output.
  - `src_o` takes the winner index.
  - `out_valid_o` goes to 1.
  - `pri` becomes the non-winner.
- Drain without accept (`out_ready_i` high, no winner): `out_valid_o` goes to 0. `out_data_o` and `src_o` hold their last values.
- Drain and accept in the same cycle: the register reloads and `out_valid_o` stays 1. This gives back-to-back throughput.
- FULL with `out_ready_i` low: all outputs hold and both readys are 0. Requesters stall.
- Requester rule: once `x_valid_i` is raised, it stays high with stable data until `x_ready_o`. `pri` changes only on accept, so the winner cannot change while a requester is waiting.

## Timing
- Reset values: `out_valid_o`=0, `out_data_o`=16'h0000, `src_o`=0, `pri`=0.
- While `rst_i` is high, `a_ready_o` and `b_ready_o` are forced to 0.
- Reset mid-transfer: a held output word is discarded and no handshake completes.
- Latency: accept in cycle N makes the word visible on `out_data_o` with `out_valid_o`=1 in cycle N+1.
- Throughput: one word per cycle when `out_ready_i` is held high.
- Readys depend combinationally on `out_ready_i`, the valids and `pri`. There is no combinational path from data inputs to readys.
- `out_valid_o`, `out_data_o` and `src_o` are registered only.

## Configuration
- `MUX16_ARB_RR_EN` defined: round-robin as above. `pri` toggles to the loser after every accept, so with both sources continuously valid the grants alternate A, B, A, B.
- `MUX16_ARB_RR_EN` undefined: fixed priority. `pri` is tied to 0, so A wins whenever `a_valid_i` is high, and B is accepted only in cycles with `a_valid_i` low. Everything else is unchanged.

## Test plan
- Reset check: assert `rst_i` with `a_valid_i`=1 -> `a_ready_o`=0, `out_valid_o`=0, `out_data_o`=0000. Release reset -> A is accepted in the first cycle; the next cycle shows `out_data_o`=`a_data_i`, `src_o`=0.
- Single source: B alone sends 16'h3BF1, `out_ready_i`=1 -> `b_ready_o`=1 for one cycle; next cycle `out_valid_o`=1, `out_data_o`=3BF1, `src_o`=1.
- Contention (RR_EN defined): A=AAAA and B=FFFF both valid for 4 cycles, `out_ready_i`=1 -> outputs AAAA, FFFF, AAAA, FFFF with `src_o` 0,1,0,1. Repeated with the macro undefined -> four words of AAAA, `b_ready_o` stays 0.
- Backpressure: hold `out_ready_i`=0 after one accept of 0000 -> `out_valid_o` stays 1, `out_data_o`=0000, both readys 0. Raise `out_ready_i` with A valid=FFFF -> drain and reload in the same cycle, `out_valid_o` never drops.
- Drain only: FULL state, `out_ready_i`=1, no valids -> next cycle `out_valid_o`=0, `out_data_o` unchanged.
- Mid-operation reset: assert `rst_i` asynchronously while FULL -> `out_valid_o`=0 immediately, without waiting for a clock edge.
